// File: rtl/regbank_mp.sv
`default_nettype none
// ============================================================================
// Module   : regbank_mp
// Purpose  : Multi-ported register bank with NUMRD read ports, NUMWR write
//            ports, write-to-read bypass, hard-wired zero register, a
//            pending-write scoreboard and write-port conflict reporting.
// Revision : 1.0 - initial release
// ============================================================================
module regbank_mp #(
  parameter int NUMREGS   = 32,
  parameter int DATAWIDTH = 32,
  parameter int NUMRD     = 2,
  parameter int NUMWR     = 2,
  localparam int AW       = $clog2(NUMREGS)
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic [NUMRD-1:0]           re_i,
  input  logic [NUMRD*AW-1:0]        raddr_i,
  output logic [NUMRD*DATAWIDTH-1:0] rdata_o,
  output logic [NUMRD-1:0]           rbusy_o,
  input  logic [NUMWR-1:0]           we_i,
  input  logic [NUMWR*AW-1:0]        waddr_i,
  input  logic [NUMWR*DATAWIDTH-1:0] wdata_i,
  input  logic                       mark_i,
  input  logic [AW-1:0]              mark_addr_i,
  output logic                       wr_conflict_o,
  output logic [15:0]                conflict_cnt_o
);

  localparam logic [15:0] C_CNT_MAX = 16'hFFFF;

  logic [DATAWIDTH-1:0] r_bank [NUMREGS];
  logic [NUMREGS-1:0]   r_busy;
  logic                 r_conflict;
  logic [15:0]          r_conflict_cnt;

  logic [NUMREGS-1:0]   w_wr_hit;
  logic                 w_conflict;

  // One bit per register: some enabled write port targets it this cycle
  always_comb begin
    w_wr_hit = '0;
    for (int w = 0; w < NUMWR; w++) begin
      if (we_i[w] && (waddr_i[w*AW +: AW] != '0)) begin
        w_wr_hit[waddr_i[w*AW +: AW]] = 1'b1;
      end
    end
  end

  // Any two enabled write ports aiming at the same nonzero register
  always_comb begin
    w_conflict = 1'b0;
    for (int i = 0; i < NUMWR; i++) begin
      for (int j = i + 1; j < NUMWR; j++) begin
        if (we_i[i] && we_i[j] &&
            (waddr_i[i*AW +: AW] == waddr_i[j*AW +: AW]) &&
            (waddr_i[i*AW +: AW] != '0)) begin
          w_conflict = 1'b1;
        end
      end
    end
  end

  // Bank update: ascending port order makes the highest-index writer win
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int r = 0; r < NUMREGS; r++) begin
        r_bank[r] <= '0;
      end
    end else begin
      for (int w = 0; w < NUMWR; w++) begin
        if (we_i[w] && (waddr_i[w*AW +: AW] != '0)) begin
          r_bank[waddr_i[w*AW +: AW]] <= wdata_i[w*DATAWIDTH +: DATAWIDTH];
        end
      end
    end
  end

  // Scoreboard: writes clear, a same-cycle mark overrides the clear
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_busy <= '0;
    end else begin
      r_busy <= r_busy & ~w_wr_hit;
      if (mark_i && (mark_addr_i != '0)) begin
        r_busy[mark_addr_i] <= 1'b1;
      end
    end
  end

  // Conflict pulse and saturating conflict counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_conflict     <= 1'b0;
      r_conflict_cnt <= '0;
    end else begin
      r_conflict <= w_conflict;
      if (w_conflict && (r_conflict_cnt != C_CNT_MAX)) begin
        r_conflict_cnt <= r_conflict_cnt + 16'd1;
      end
    end
  end

  assign wr_conflict_o  = r_conflict;
  assign conflict_cnt_o = r_conflict_cnt;

  for (genvar k = 0; k < NUMRD; k++) begin : g_rd
    logic [AW-1:0]        w_addr;
    logic                 w_hit;
    logic [DATAWIDTH-1:0] w_data;

    assign w_addr = raddr_i[k*AW +: AW];

    // Bank lookup overridden by the highest-index matching live write
    always_comb begin
      w_hit  = 1'b0;
      w_data = r_bank[w_addr];
      for (int w = 0; w < NUMWR; w++) begin
        if (we_i[w] && (waddr_i[w*AW +: AW] == w_addr)) begin
          w_hit  = 1'b1;
          w_data = wdata_i[w*DATAWIDTH +: DATAWIDTH];
        end
      end
    end

    assign rdata_o[k*DATAWIDTH +: DATAWIDTH] =
      (re_i[k] && (w_addr != '0)) ? w_data : '0;
    assign rbusy_o[k] = re_i[k] && (w_addr != '0) && r_busy[w_addr] && !w_hit;
  end

endmodule
`default_nettype wire
